// File: rtl/dual_issue_scoreboard.sv
// Dual-issue hazard scoreboard: holds one even/odd pair and issues
// each slot once its RAW/WAW countdowns have drained, even first.
module dual_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              even_valid,
  input  logic [ADDR_W-1:0] even_ra,
  input  logic [ADDR_W-1:0] even_rb,
  input  logic [ADDR_W-1:0] even_rc,
  input  logic [2:0]        even_use,
  input  logic [ADDR_W-1:0] even_rt,
  input  logic              even_wr,
  input  logic [LAT_W-1:0]  even_lat,
  input  logic              odd_valid,
  input  logic [ADDR_W-1:0] odd_ra,
  input  logic [ADDR_W-1:0] odd_rb,
  input  logic [ADDR_W-1:0] odd_rt_st,
  input  logic [2:0]        odd_use,
  input  logic [ADDR_W-1:0] odd_rt,
  input  logic              odd_wr,
  input  logic [LAT_W-1:0]  odd_lat,
  input  logic              flush,
  output logic              issue_even,
  output logic              issue_odd,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef struct packed {
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rc;
    logic [2:0]        srcs;
    logic [ADDR_W-1:0] rt;
    logic              wr;
    logic [LAT_W-1:0]  lat;
  } slot_t;

  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

  logic             he_q, he_d;
  logic             ho_q, ho_d;
  slot_t            e_q, e_d;
  slot_t            o_q, o_d;
  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             e_src_ok, e_dst_ok;
  logic             o_src_ok, o_dst_ok;
  logic             dep;
  logic             even_go, odd_go;
  logic [LAT_W-1:0] e_lat, o_lat;

  assign e_src_ok =
    (!e_q.srcs[2] || cnt_q[e_q.ra] == '0) &&
    (!e_q.srcs[1] || cnt_q[e_q.rb] == '0) &&
    (!e_q.srcs[0] || cnt_q[e_q.rc] == '0);
  assign e_dst_ok = !e_q.wr || cnt_q[e_q.rt] == '0;

  assign o_src_ok =
    (!o_q.srcs[2] || cnt_q[o_q.ra] == '0) &&
    (!o_q.srcs[1] || cnt_q[o_q.rb] == '0) &&
    (!o_q.srcs[0] || cnt_q[o_q.rc] == '0);
  assign o_dst_ok = !o_q.wr || cnt_q[o_q.rt] == '0;

  // Same-cycle pairing is only legal when odd neither reads nor
  // overwrites the register even is about to claim.
  assign dep = e_q.wr && (
    (o_q.srcs[2] && o_q.ra == e_q.rt) ||
    (o_q.srcs[1] && o_q.rb == e_q.rt) ||
    (o_q.srcs[0] && o_q.rc == e_q.rt) ||
    (o_q.wr && o_q.rt == e_q.rt));

  assign even_go = he_q && e_src_ok && e_dst_ok && !flush;
  assign odd_go  = ho_q && o_src_ok && o_dst_ok && !flush &&
                   (!he_q || (even_go && !dep));

  assign issue_even   = even_go;
  assign issue_odd    = odd_go;
  assign stall_cycles = stall_q;

  assign in_ready = ((!he_q || even_go) && (!ho_q || odd_go)) ||
                    flush;

  assign e_lat = (e_q.lat == '0) ? ONE : e_q.lat;
  assign o_lat = (o_q.lat == '0) ? ONE : o_q.lat;

  always_comb begin
    he_d = he_q && !even_go;
    ho_d = ho_q && !odd_go;
    e_d  = e_q;
    o_d  = o_q;
    if (flush) begin
      he_d = 1'b0;
      ho_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      he_d      = even_valid;
      ho_d      = odd_valid;
      e_d.ra    = even_ra;
      e_d.rb    = even_rb;
      e_d.rc    = even_rc;
      e_d.srcs  = even_use;
      e_d.rt    = even_rt;
      e_d.wr    = even_wr;
      e_d.lat   = even_lat;
      o_d.ra    = odd_ra;
      o_d.rb    = odd_rb;
      o_d.rc    = odd_rt_st;
      o_d.srcs  = odd_use;
      o_d.rt    = odd_rt;
      o_d.wr    = odd_wr;
      o_d.lat   = odd_lat;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (even_go && e_q.wr && e_q.rt == ADDR_W'(r))
        cnt_d[r] = e_lat;
      else if (odd_go && o_q.wr && o_q.rt == ADDR_W'(r))
        cnt_d[r] = o_lat;
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - ONE;
      else
        cnt_d[r] = cnt_q[r];
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((he_q || ho_q) && !even_go && !odd_go && !flush)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      he_q    <= 1'b0;
      ho_q    <= 1'b0;
      e_q     <= '0;
      o_q     <= '0;
      cnt_q   <= '{default: '0};
      stall_q <= '0;
    end else begin
      he_q    <= he_d;
      ho_q    <= ho_d;
      e_q     <= e_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule
